// File: rtl/systolic_feeder.sv
// Operand feeder for systolic_array: buffers one SIZE x SIZE A/B pair, then
// replays it as diagonally skewed lane streams with clear/done sequencing.
`timescale 1ns/1ps

module systolic_feeder #(
   parameter int DATA_WIDTH   = 8,
   parameter int SIZE         = 4,
   parameter int DRAIN_CYCLES = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DATA_WIDTH*SIZE-1:0] a_row,
   input  logic [DATA_WIDTH*SIZE-1:0] b_row,
   output logic [DATA_WIDTH*SIZE-1:0] a_out,
   output logic [DATA_WIDTH*SIZE-1:0] b_out,
   output logic                       feed_valid,
   output logic                       acc_clr,
   output logic                       done
);

   // state | meaning
   // LOAD  | accepting row beats into A/B storage, in_ready high
   // CLEAR | one-cycle acc_clr pulse before the product starts
   // FEED  | 2*SIZE-1 skewed wavefronts on a_out/b_out
   // DRAIN | DRAIN_CYCLES idle cycles while the array finishes
   // DONE  | one-cycle done pulse, then rearm to LOAD

   localparam int W  = DATA_WIDTH * SIZE;
   localparam int RW = (SIZE > 1) ? $clog2(SIZE) : 1;
   localparam int KW = $clog2(2 * SIZE);
   localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   localparam logic [RW-1:0] ROW_LAST   = RW'(SIZE - 1);
   localparam logic [KW-1:0] K_LAST     = KW'(2 * SIZE - 2);
   localparam logic [DW-1:0] DRAIN_LOAD = DW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

   typedef enum logic [2:0] {
      S_LOAD,
      S_CLEAR,
      S_FEED,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t        state;
   logic [RW-1:0] row_cnt;
   logic [KW-1:0] k_cnt;
   logic [DW-1:0] drain_cnt;
   logic [W-1:0]  a_mem [SIZE];
   logic [W-1:0]  b_mem [SIZE];

   logic [KW-1:0] k_next;
   logic [W-1:0]  a_lanes;
   logic [W-1:0]  b_lanes;

   assign in_ready = (state == S_LOAD) && !rst;

   always_comb begin
      k_next = '0;
      if (state == S_FEED) begin
         k_next = k_cnt + KW'(1);
      end
   end

   // Wavefront k holds every element whose row+column index equals k.
   always_comb begin
      a_lanes = '0;
      b_lanes = '0;
      for (int r = 0; r < SIZE; r++) begin
         for (int c = 0; c < SIZE; c++) begin
            if (r + c == int'(k_next)) begin
               a_lanes[r*DATA_WIDTH +: DATA_WIDTH] = a_mem[r][c*DATA_WIDTH +: DATA_WIDTH];
               b_lanes[c*DATA_WIDTH +: DATA_WIDTH] = b_mem[r][c*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_LOAD;
         row_cnt    <= '0;
         k_cnt      <= '0;
         drain_cnt  <= '0;
         a_out      <= '0;
         b_out      <= '0;
         feed_valid <= 1'b0;
         acc_clr    <= 1'b0;
         done       <= 1'b0;
         for (int r = 0; r < SIZE; r++) begin
            a_mem[r] <= '0;
            b_mem[r] <= '0;
         end
      end else begin
         acc_clr <= 1'b0;
         done    <= 1'b0;
         case (state)
            S_LOAD: begin
               if (in_valid) begin
                  a_mem[row_cnt] <= a_row;
                  b_mem[row_cnt] <= b_row;
                  if (row_cnt == ROW_LAST) begin
                     row_cnt <= '0;
                     state   <= S_CLEAR;
                     acc_clr <= 1'b1;
                  end else begin
                     row_cnt <= row_cnt + RW'(1);
                  end
               end
            end
            S_CLEAR: begin
               state      <= S_FEED;
               k_cnt      <= '0;
               a_out      <= a_lanes;
               b_out      <= b_lanes;
               feed_valid <= 1'b1;
            end
            S_FEED: begin
               if (k_cnt == K_LAST) begin
                  k_cnt      <= '0;
                  a_out      <= '0;
                  b_out      <= '0;
                  feed_valid <= 1'b0;
                  if (DRAIN_CYCLES == 0) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state     <= S_DRAIN;
                     drain_cnt <= DRAIN_LOAD;
                  end
               end else begin
                  k_cnt <= k_next;
                  a_out <= a_lanes;
                  b_out <= b_lanes;
               end
            end
            S_DRAIN: begin
               if (drain_cnt == '0) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt - DW'(1);
               end
            end
            S_DONE: begin
               state <= S_LOAD;
            end
            default: begin
               state <= S_LOAD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_systolic_feeder.sv
// Randomized bench for systolic_feeder: a cycle-schedule model derived from the
// wavefront rules is compared against every DUT output on every cycle.
`timescale 1ns/1ps

module tb_systolic_feeder;
   localparam int DW     = 8;
   localparam int S      = 4;
   localparam int D      = 8;
   localparam int W      = DW * S;
   localparam int T_DONE = 2 * S + D + 1;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a_row = '0;
   logic [W-1:0] b_row = '0;
   logic [W-1:0] a_out;
   logic [W-1:0] b_out;
   logic         feed_valid;
   logic         acc_clr;
   logic         done;

   always #5 clk = ~clk;

   systolic_feeder #(.DATA_WIDTH(DW), .SIZE(S), .DRAIN_CYCLES(D)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a_row(a_row), .b_row(b_row), .a_out(a_out), .b_out(b_out),
      .feed_valid(feed_valid), .acc_clr(acc_clr), .done(done)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] pk(input int v0, input int v1, input int v2, input int v3);
      return {8'(v3), 8'(v2), 8'(v1), 8'(v0)};
   endfunction

   // Reference model: stored matrices plus cycles elapsed since the last accepted beat.
   logic signed [DW-1:0] ma [S][S];
   logic signed [DW-1:0] mb [S][S];
   int t    = 0;
   int rows = 0;
   int cyc  = 0;

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         t = 0;
         rows = 0;
      end else if (t == 0) begin
         if (in_valid) begin
            for (int c = 0; c < S; c++) begin
               ma[rows][c] = a_row[c*DW +: DW];
               mb[rows][c] = b_row[c*DW +: DW];
            end
            rows++;
            if (rows == S) begin
               rows = 0;
               t = 1;
            end
         end
      end else if (t == T_DONE) begin
         t = 0;
      end else begin
         t++;
      end
   end

   function automatic logic [W-1:0] exp_a(input int k);
      logic [W-1:0] r = '0;
      for (int i = 0; i < S; i++)
         if (k - i >= 0 && k - i < S) r[i*DW +: DW] = ma[i][k-i];
      return r;
   endfunction

   function automatic logic [W-1:0] exp_b(input int k);
      logic [W-1:0] r = '0;
      for (int j = 0; j < S; j++)
         if (k - j >= 0 && k - j < S) r[j*DW +: DW] = mb[k-j][j];
      return r;
   endfunction

   logic [2*W-1:0] cap [2][2*S-1];
   int cap_sel  = -1;
   int lit_mode = 0;
   int fv_cnt   = 0;
   int last_fv  = 0;
   int done_at  = 0;

   always @(negedge clk) begin
      logic [W-1:0] ea, eb;
      logic er, ec, ef, ed;
      if (rst) begin
         ea = '0; eb = '0; er = 1'b0; ec = 1'b0; ef = 1'b0; ed = 1'b0;
      end else begin
         er = (t == 0);
         ec = (t == 1);
         ef = (t >= 2 && t <= 2 * S);
         ed = (t == T_DONE);
         ea = ef ? exp_a(t - 2) : '0;
         eb = ef ? exp_b(t - 2) : '0;
      end
      check("in_ready", in_ready, er);
      check("acc_clr", acc_clr, ec);
      check("feed_valid", feed_valid, ef);
      check("done", done, ed);
      check("a_out", a_out, ea);
      check("b_out", b_out, eb);
      if (feed_valid) begin
         fv_cnt++;
         last_fv = cyc;
      end
      if (done) done_at = cyc;
      if (!rst && ef && cap_sel >= 0) cap[cap_sel][t-2] = {a_out, b_out};
      if (!rst && lit_mode == 1) begin
         if (t == 1) check("lit_acc_clr", acc_clr, 1'b1);
         if (t == 2) begin
            check("lit_k0_a", a_out, pk(1, 0, 0, 0));
            check("lit_k0_b", b_out, pk(1, 0, 0, 0));
         end
         if (t == 5) begin
            check("lit_k3_a", a_out, pk(4, 7, 10, 13));
            check("lit_k3_b", b_out, pk(13, 10, 7, 4));
         end
         if (t == 8) begin
            check("lit_k6_a", a_out, pk(0, 0, 0, 16));
            check("lit_k6_b", b_out, pk(0, 0, 0, 16));
         end
      end
      if (!rst && lit_mode == 2 && t == 2) begin
         check("lit_signed_a0", a_out[7:0], 8'h80);
         check("lit_signed_b0", b_out[7:0], 8'hFF);
      end
   end

   logic [W-1:0] src_a [S];
   logic [W-1:0] src_b [S];

   task automatic wait_load();
      int n = 0;
      while (t != 0 || rst) begin
         @(negedge clk);
         n++;
         if (n > 200) begin
            check("timeout_wait_load", 64'(t), 64'd0);
            break;
         end
      end
   endtask

   // gap_mode 0: back-to-back, 1: one idle cycle after each beat, 2: random idles
   task automatic load(input int gap_mode);
      wait_load();
      for (int r = 0; r < S; r++) begin
         int g;
         @(negedge clk);
         in_valid = 1'b1;
         a_row = src_a[r];
         b_row = src_b[r];
         g = (gap_mode == 2) ? int'($urandom_range(0, 2)) : gap_mode;
         repeat (g) begin
            @(negedge clk);
            in_valid = 1'b0;
            a_row = $urandom;
            b_row = $urandom;
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      a_row = $urandom;
      b_row = $urandom;
   endtask

   task automatic run_to_end(input bit hold);
      int n = 0;
      forever begin
         if (t == T_DONE) break;
         if (hold) begin
            in_valid = 1'b1;
            a_row = $urandom;
            b_row = $urandom;
         end
         @(negedge clk);
         n++;
         if (n > 100) begin
            check("timeout_run", 64'(t), 64'(T_DONE));
            break;
         end
      end
      in_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic random_src();
      for (int r = 0; r < S; r++) begin
         src_a[r] = $urandom;
         src_b[r] = $urandom;
      end
   endtask

   initial begin
      // Reset with in_valid offered: nothing may be accepted.
      in_valid = 1'b1;
      a_row = $urandom;
      b_row = $urandom;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("ready_after_rst", in_ready, 1'b1);

      // Run 1: literal matrices, back-to-back load.
      for (int r = 0; r < S; r++) begin
         src_a[r] = pk(4*r+1, 4*r+2, 4*r+3, 4*r+4);
         src_b[r] = src_a[r];
      end
      lit_mode = 1; cap_sel = 0; fv_cnt = 0;
      load(0);
      run_to_end(0);
      lit_mode = 0;
      check("feed_len_run1", 64'(fv_cnt), 64'd7);
      check("done_gap_run1", 64'(done_at - last_fv), 64'd9);

      // Run 2: same matrices, gapped load, in_valid held through FEED/DRAIN.
      cap_sel = 1; fv_cnt = 0;
      load(1);
      run_to_end(1);
      cap_sel = -1;
      check("feed_len_run2", 64'(fv_cnt), 64'd7);
      for (int k = 0; k < 2 * S - 1; k++) check("replay_match", cap[1][k], cap[0][k]);

      // Run 3: signed extremes.
      random_src();
      src_a[0][7:0] = 8'h80;
      src_b[0][7:0] = 8'hFF;
      lit_mode = 2;
      load(0);
      run_to_end(0);
      lit_mode = 0;

      // Run 4: reset at FEED k=2.
      random_src();
      load(0);
      begin
         int n = 0;
         while (t != 4 && n < 50) begin
            @(negedge clk);
            n++;
         end
         check("reach_k2", 64'(t), 64'd4);
      end
      #1 rst = 1'b1;
      #1;
      check("rst_a_out", a_out, '0);
      check("rst_feed_valid", feed_valid, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("ready_after_mid_rst", in_ready, 1'b1);

      // Randomized runs.
      for (int n = 0; n < 8; n++) begin
         random_src();
         fv_cnt = 0;
         load(2);
         run_to_end(bit'($urandom_range(0, 1)));
         check("feed_len_rand", 64'(fv_cnt), 64'd7);
      end

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
Upstream stage of systolic_array. Buffers one SIZE x SIZE operand pair (matrix A row-wise, matrix B row-wise) through a valid/ready load port. Replays the pair as diagonally skewed lane streams, so lane i of A and lane j of B reach the array edge on the correct wavefront. Drives the array's a_in/b_in buses, sequences an accumulator-clear pulse and a done pulse, then rearms for the next pair.

Parameters:
DATA_WIDTH, 8, signed element width.
SIZE, 4, matrix dimension; lanes per bus.
DRAIN_CYCLES, 8, idle cycles after the feed so the array finishes propagating before done.

Ports:
clk  input  1  system clock; all state on rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  load beat offered.
in_ready  output  1  feeder accepts a load beat this cycle.
a_row  input  DATA_WIDTH*SIZE  row r of A; element A[r][c] at bits [c*DATA_WIDTH +: DATA_WIDTH].
b_row  input  DATA_WIDTH*SIZE  row r of B; same packing as a_row.
a_out  output  DATA_WIDTH*SIZE  skewed A stream to array a_in; lane i at [i*DATA_WIDTH +: DATA_WIDTH].
b_out  output  DATA_WIDTH*SIZE  skewed B stream to array b_in; lane j, same packing.
feed_valid  output  1  high while a_out/b_out carry FEED data.
acc_clr  output  1  one-cycle pulse telling the array/accumulators to clear before a new product.
done  output  1  one-cycle pulse when the product is complete at the array output.

Behaviour:
- Reset (async assert, sync release): state=LOAD, row counter=0, feed/drain counters=0, A/B storage=0. a_out=0, b_out=0, feed_valid=0, acc_clr=0, done=0. in_ready=1 once rst deasserts.
- States: LOAD -> CLEAR -> FEED -> DRAIN -> DONE -> LOAD.
- LOAD:
  - in_ready=1.
  - Beat accepted when in_valid&&in_ready at a rising edge: a_row stored as A[row_cnt], b_row as B[row_cnt], row_cnt++.
  - Gaps in in_valid are allowed; only accepted beats count.
  - The edge accepting beat SIZE-1 moves to CLEAR and resets row_cnt.
- CLEAR: exactly 1 cycle. acc_clr=1, outputs zero, in_ready=0.
- FEED: exactly 2*SIZE-1 cycles, k=0..2*SIZE-2. feed_valid=1. All outputs are registered (from state/counter/storage) and stable for the whole cycle.
  - a_out lane i = A[i][k-i] if 0<=k-i<SIZE, else 0.
  - b_out lane j = B[k-j][j] if 0<=k-j<SIZE, else 0.
- DRAIN: exactly DRAIN_CYCLES cycles. Outputs 0, feed_valid=0. DRAIN_CYCLES=0 skips straight to DONE.
- DONE: 1 cycle, done=1. Next cycle is LOAD with in_ready=1.
- in_ready=0 in every state except LOAD. in_valid outside LOAD is ignored and stores nothing.
- Timing from the edge accepting the last beat, with defaults: acc_clr in cycle 1, FEED in cycles 2..8, DRAIN in 9..16, done in 17, in_ready high in 18.
- Data is passed unmodified (no arithmetic), so width and sign are preserved. Negative values appear bit-exact on the lanes.
- rst asserted in any state aborts immediately to the reset values above; a partial load is discarded.

Test Plan:
- Reset: hold rst, drive in_valid=1 -> in_ready=0 during reset, all outputs 0, nothing stored. After release, in_ready=1 and row_cnt=0.
- Load then feed, SIZE=4, A=B=[[1,2,3,4],[5,6,7,8],[9,10,11,12],[13,14,15,16]], four back-to-back beats:
  - Cycle after last accept -> acc_clr=1.
  - FEED k=0: a lanes {1,0,0,0}, b lanes {1,0,0,0}.
  - k=3: a lanes {4,7,10,13}, b lanes {13,10,7,4}.
  - k=6: a lanes {0,0,0,16}, b lanes {0,0,0,16}.
  - feed_valid high for exactly 7 cycles; done exactly 9 cycles after the last FEED cycle.
- Gapped load: in_valid toggles 1,0,1,0,... -> only the 4 accepted rows are stored. CLEAR follows the 4th accept, not the 4th cycle.
- Backpressure: in_valid=1 held throughout FEED/DRAIN with different rows -> in_ready=0, stored matrices unchanged, FEED output identical to the previous run.
- Signed data: A[0][0]=-128, B[0][0]=-1 -> FEED k=0 a lane0=8'h80, b lane0=8'hFF.
- Mid-operation reset: assert rst at FEED k=2 -> outputs 0 the same cycle. After release, in_ready=1; a fresh full load/feed sequence produces correct values with no residue from the prior matrices.
